// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared types, defaults and float ordering key for the top-K selector
package topk_pkg;

  typedef enum logic [1:0] {
    ST_ACC    = 2'd0,
    ST_INSERT = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  localparam int DEF_LOG_INPUT_NUM = 4;
  localparam int DEF_LANES         = 1 << DEF_LOG_INPUT_NUM;
  localparam int DEF_K             = 4;
  localparam int DEF_CNT_W         = $clog2(DEF_K + 1);
  localparam int KEY_MAX_W         = 64;

  // Maps a w-bit IEEE-754 pattern onto an unsigned key with the same order:
  // negatives get every bit inverted, positives get only the sign flipped.
  // Callers pass the element zero-extended and keep the low w bits.
  function automatic logic [KEY_MAX_W-1:0] float_to_key(
    input logic [KEY_MAX_W-1:0] v,
    input int                   w
  );
    logic [KEY_MAX_W-1:0] m;
    m = (64'd1 << w) - 64'd1;
    if (v[w-1])
      return ~v & m;
    else
      return (v ^ (64'd1 << (w - 1))) & m;
  endfunction

endpackage

// File: rtl/topk_insert_list.sv
// rtl/topk_insert_list.sv - K-slot sorted list with parallel compare and shift-insert
module topk_insert_list
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K          = DEF_K,
  parameter int IDX_WIDTH  = 16,
  parameter int CNT_W      = $clog2(K + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    ins_en,
  input  logic [DATA_WIDTH-1:0]   key,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [IDX_WIDTH-1:0]    idx,
  input  logic                    mode,
  output logic [DATA_WIDTH*K-1:0] slot_data,
  output logic [IDX_WIDTH*K-1:0]  slot_idx,
  output logic [CNT_W-1:0]        count
);

  logic [DATA_WIDTH-1:0] key_q  [K];
  logic [DATA_WIDTH-1:0] data_q [K];
  logic [IDX_WIDTH-1:0]  idx_q  [K];
  logic [CNT_W-1:0]      pos;

  // Insert position = number of filled slots at least as good as the new key;
  // counting equal keys as better keeps the earlier index ahead on ties.
  always_comb begin
    pos = '0;
    for (int i = 0; i < K; i++) begin
      if ((CNT_W'(i) < count) && (mode ? (key_q[i] <= key) : (key_q[i] >= key)))
        pos = pos + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_out
    assign slot_data[DATA_WIDTH*(g+1)-1 -: DATA_WIDTH] = data_q[g];
    assign slot_idx[IDX_WIDTH*(g+1)-1 -: IDX_WIDTH]    = idx_q[g];
  end

  // Slots below pos hold, slot pos takes the new element, the tail shifts down
  // one and the old last slot falls off; pos == K discards the element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      count <= '0;
    end else if (clear) begin
      for (int i = 0; i < K; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      count <= '0;
    end else if (ins_en && (pos < CNT_W'(K))) begin
      for (int i = K - 1; i >= 1; i--) begin
        if (CNT_W'(i) > pos) begin
          key_q[i]  <= key_q[i-1];
          data_q[i] <= data_q[i-1];
          idx_q[i]  <= idx_q[i-1];
        end else if (CNT_W'(i) == pos) begin
          key_q[i]  <= key;
          data_q[i] <= data;
          idx_q[i]  <= idx;
        end
      end
      if (pos == '0) begin
        key_q[0]  <= key;
        data_q[0] <= data;
        idx_q[0]  <= idx;
      end
      if (count != CNT_W'(K))
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/topk_stream.sv
// rtl/topk_stream.sv - streaming top-K selector over multi-beat float sets
module topk_stream
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int LOG_INPUT_NUM = DEF_LOG_INPUT_NUM,
  parameter int K             = DEF_K,
  parameter int IDX_WIDTH     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0] x,
  input  logic [(1<<LOG_INPUT_NUM)-1:0]          i_mask,
  input  logic                                   i_last,
  input  logic                                   i_mode,
  input  logic                                   i_valid,
  output logic                                   i_ready,
  output logic [DATA_WIDTH*K-1:0]                y,
  output logic [IDX_WIDTH*K-1:0]                 o_idx,
  output logic [$clog2(K+1)-1:0]                 o_count,
  output logic                                   o_valid,
  input  logic                                   o_ready
);

  localparam int LANES  = 1 << LOG_INPUT_NUM;
  localparam int CNT_W  = $clog2(K + 1);
  localparam int LANE_W = LOG_INPUT_NUM + 1;

  state_t                              state_q, state_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]    x_r;
  logic [LANES-1:0]                    mask_r;
  logic                                last_r;
  logic                                mode_r;
  logic [LANE_W-1:0]                   lane_cnt;
  logic [LOG_INPUT_NUM-1:0]            lane_sel;
  logic [IDX_WIDTH-1:0]                beat_cnt;
  logic [DATA_WIDTH-1:0]               lane_data;
  logic                                in_hs, out_hs;

  // One-stage pipe between lane mux and list: lane conversion and the K-wide
  // compare land in different cycles.
  logic                                ins_v;
  logic [DATA_WIDTH-1:0]               ins_key;
  logic [DATA_WIDTH-1:0]               ins_data;
  logic [IDX_WIDTH-1:0]                ins_idx;

  assign i_ready   = (state_q == ST_ACC);
  assign o_valid   = (state_q == ST_OUT);
  assign in_hs     = i_valid && i_ready;
  assign out_hs    = o_valid && o_ready;
  assign lane_sel  = lane_cnt[LOG_INPUT_NUM-1:0];
  assign lane_data = x_r[lane_sel];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // Next state: a non-final beat returns to ACC after its last lane, while the
  // final beat spends one more cycle in INSERT so its last lane drains from the
  // pipe into the list before OUT presents the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC: begin
        if (i_valid) state_d = ST_INSERT;
      end
      ST_INSERT: begin
        if (lane_cnt == LANE_W'(LANES))
          state_d = ST_OUT;
        else if ((lane_cnt == LANE_W'(LANES - 1)) && !last_r)
          state_d = ST_ACC;
      end
      ST_OUT: begin
        if (o_ready) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // Input registers and lane/beat counters; mode is captured only on the
  // first beat of a set so later changes cannot reorder a list in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r      <= '0;
      mask_r   <= '0;
      last_r   <= 1'b0;
      mode_r   <= 1'b0;
      lane_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (in_hs) begin
        x_r      <= x;
        mask_r   <= i_mask;
        last_r   <= i_last;
        lane_cnt <= '0;
        if (beat_cnt == '0) mode_r <= i_mode;
      end
      if (state_q == ST_INSERT) begin
        lane_cnt <= lane_cnt + LANE_W'(1);
        if ((lane_cnt == LANE_W'(LANES - 1)) && !last_r)
          beat_cnt <= beat_cnt + IDX_WIDTH'(1);
      end
      if (out_hs) beat_cnt <= '0;
    end
  end

  // Lane pipe: key, payload and global index (beat*LANES + lane, wrapping).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_v    <= 1'b0;
      ins_key  <= '0;
      ins_data <= '0;
      ins_idx  <= '0;
    end else begin
      ins_v    <= (state_q == ST_INSERT) && (lane_cnt < LANE_W'(LANES)) && mask_r[lane_sel];
      ins_key  <= DATA_WIDTH'(float_to_key(KEY_MAX_W'(lane_data), DATA_WIDTH));
      ins_data <= lane_data;
      ins_idx  <= IDX_WIDTH'({beat_cnt, lane_sel});
    end
  end

  topk_insert_list #(
    .DATA_WIDTH (DATA_WIDTH),
    .K          (K),
    .IDX_WIDTH  (IDX_WIDTH),
    .CNT_W      (CNT_W)
  ) u_list (
    .clk       (clk),
    .rst       (rst),
    .clear     (out_hs),
    .ins_en    (ins_v),
    .key       (ins_key),
    .data      (ins_data),
    .idx       (ins_idx),
    .mode      (mode_r),
    .slot_data (y),
    .slot_idx  (o_idx),
    .count     (o_count)
  );

endmodule
